display_scene_controller: RTL and testbench
===========================================

# display_scene_controller

Frame-synchronous game-scene sequencer for the fencing display path. Tracks the match state (start screen, countdown, play, hit flash, game over), owns both health counters, and drives the layer-enable mask, `start_display` select and flash/winner controls consumed by the display pixel mux and the overlay generators. Every visible output changes only at a frame boundary, so a frame never mixes two scenes.

## Interface
Parameters:
- `MAX_HEALTH`, 8: starting health per fencer (1..15)
- `STEP_FRAMES`, 60: frames per countdown digit (1..1023)
- `FLASH_FRAMES`, 12: frames spent in HIT_FLASH (1..1023)
- `GAMEOVER_FRAMES`, 300: frames in GAME_OVER before returning to IDLE (1..1023)

Ports:
- `clk_in`  in  1  pixel clock
- `rst_n_in`  in  1  reset; one clock, asynchronous, active-low
- `frame_start_in`  in  1  one-cycle pulse, once per frame, at the start of vertical blanking
- `start_btn_in`  in  1  debounced start button level
- `player_hit_in`  in  1  one-cycle pulse: player touched opponent
- `opponent_hit_in`  in  1  one-cycle pulse: opponent touched player
- `layer_en_out`  out  9  layer enables; bit0 border, 1 camera, 2 start, 3 player box, 4 opponent box, 5 player saber, 6 opponent saber, 7 health bars, 8 player line
- `start_display_out`  out  1  selects the start-screen layer in the mux
- `player_health_out`, `opponent_health_out`  out  4  current health
- `flash_out`  out  1  hit-flash overlay enable
- `countdown_out`  out  2  digit shown during countdown (3,2,1), otherwise 0
- `winner_out`  out  2  0 none, 1 player, 2 opponent, 3 draw
- `state_out`  out  3  0 IDLE, 1 COUNTDOWN, 2 PLAY, 3 HIT_FLASH, 4 GAME_OVER

## Operation
- Event latches (sticky, cleared on every frame boundary): `start_req` set on a rising edge of `start_btn_in`; `p_hit`, `o_hit` set by their pulses. An event in the same cycle as `frame_start_in` belongs to the frame being closed.
- State transitions, frame counter and all outputs update only on `frame_start_in` cycles. The frame counter resets to 0 on every state entry.
- IDLE: enables 0x007, `start_display_out`=1. `start_req` -> COUNTDOWN; both healths load `MAX_HEALTH`; `winner_out`=0.
- COUNTDOWN: enables 0x19B. `countdown_out` = 3, then 2, then 1, each held for `STEP_FRAMES` frames. After 3*`STEP_FRAMES` frames -> PLAY, `countdown_out`=0. Hits are discarded.
- PLAY: enables 0x1FB. `p_hit` decrements opponent health; `o_hit` decrements player health. Both set is a double touch: both decrement. Health saturates at 0. Any processed hit -> HIT_FLASH.
- HIT_FLASH: enables 0x1FB, `flash_out`=1. Hits are discarded. After `FLASH_FRAMES` frames: -> GAME_OVER if either health is 0, else -> PLAY.
- GAME_OVER: enables 0x087, `start_display_out`=1. `winner_out` is set on entry: player 1 if only the opponent is at 0, 2 if only the player is at 0, 3 if both are at 0. After `GAMEOVER_FRAMES` frames -> IDLE; healths and `winner_out` hold until the next COUNTDOWN entry.
- `start_req` is ignored outside IDLE.

## Timing
- Reset (async assert, sync release): state IDLE, `layer_en_out`=0x007, `start_display_out`=1, both healths=`MAX_HEALTH`, `flash_out`=0, `countdown_out`=0, `winner_out`=0, all latches and counters 0.
- All outputs are registered. The new value appears on the first rising edge at which `frame_start_in`=1 is sampled, so it is valid during the following blanking interval.
- Reset asserted mid-frame or mid-state: immediate return to reset values; pending latches are lost.
- Frame counter is 10 bits and never wraps, because every state exits at or before its terminal count.

## Test plan
- Reset, then 5 frames with no inputs -> state 0, `layer_en_out`=0x007, `start_display_out`=1, healths 8/8.
- Press start mid-frame in IDLE -> next frame boundary gives state 1, `countdown_out`=3; frame 60 gives 2, frame 120 gives 1, frame 180 gives state 2, enables 0x1FB.
- In PLAY, `player_hit_in` pulse -> next boundary gives opponent health 7, state 3, `flash_out`=1. A hit injected during the flash is ignored. After 12 frames: state 2, `flash_out`=0.
- `player_hit_in` and `opponent_hit_in` in the same frame with healths 1/1 -> both 0, state 3; after the flash: state 4, `winner_out`=3, enables 0x087.
- Hit pulse coincident with `frame_start_in` -> counted on that boundary. Hit one cycle after it -> counted on the next boundary.
- `rst_n_in` asserted during HIT_FLASH -> outputs return to reset values asynchronously; after release, start press works normally.

Source files
------------

// File: rtl/display_scene_controller.sv
// Frame-synchronous match sequencer: state, health and overlay controls change only on frame_start_in.
// Outputs are registered one clock after a sampled frame boundary; events latch until that boundary (no backpressure).
module display_scene_controller #(
  parameter int unsigned MAX_HEALTH      = 8,
  parameter int unsigned STEP_FRAMES     = 60,
  parameter int unsigned FLASH_FRAMES    = 12,
  parameter int unsigned GAMEOVER_FRAMES = 300
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       frame_start_in,
  input  logic       start_btn_in,
  input  logic       player_hit_in,
  input  logic       opponent_hit_in,
  output logic [8:0] layer_en_out,
  output logic       start_display_out,
  output logic [3:0] player_health_out,
  output logic [3:0] opponent_health_out,
  output logic       flash_out,
  output logic [1:0] countdown_out,
  output logic [1:0] winner_out,
  output logic [2:0] state_out
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAY      = 3'd2,
    S_HIT_FLASH = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  localparam logic [8:0] EN_IDLE  = 9'h007;
  localparam logic [8:0] EN_COUNT = 9'h19B;
  localparam logic [8:0] EN_PLAY  = 9'h1FB;
  localparam logic [8:0] EN_OVER  = 9'h087;

  localparam logic [9:0] STEP_LAST  = 10'(STEP_FRAMES - 1);
  localparam logic [9:0] FLASH_LAST = 10'(FLASH_FRAMES - 1);
  localparam logic [9:0] OVER_LAST  = 10'(GAMEOVER_FRAMES - 1);
  localparam logic [3:0] HEALTH_INIT = 4'(MAX_HEALTH);

  state_t     state;
  logic [9:0] frame_cnt;
  logic       btn_q;
  logic       start_req;
  logic       p_hit;
  logic       o_hit;

  // Events arriving on the boundary cycle itself still belong to the closing frame.
  logic start_ev;
  logic p_ev;
  logic o_ev;
  assign start_ev = start_req | (start_btn_in & ~btn_q);
  assign p_ev     = p_hit | player_hit_in;
  assign o_ev     = o_hit | opponent_hit_in;

  assign state_out = state;

  function automatic logic [3:0] dec_sat(input logic [3:0] h, input logic en);
    return (en && h != 4'd0) ? h - 4'd1 : h;
  endfunction

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state               <= S_IDLE;
      frame_cnt           <= '0;
      btn_q               <= 1'b0;
      start_req           <= 1'b0;
      p_hit               <= 1'b0;
      o_hit               <= 1'b0;
      layer_en_out        <= EN_IDLE;
      start_display_out   <= 1'b1;
      player_health_out   <= HEALTH_INIT;
      opponent_health_out <= HEALTH_INIT;
      flash_out           <= 1'b0;
      countdown_out       <= 2'd0;
      winner_out          <= 2'd0;
    end else begin
      btn_q <= start_btn_in;
      if (!frame_start_in) begin
        start_req <= start_ev;
        p_hit     <= p_ev;
        o_hit     <= o_ev;
      end else begin
        start_req <= 1'b0;
        p_hit     <= 1'b0;
        o_hit     <= 1'b0;
        case (state)
          S_IDLE: begin
            if (start_ev) begin
              state               <= S_COUNTDOWN;
              frame_cnt           <= '0;
              player_health_out   <= HEALTH_INIT;
              opponent_health_out <= HEALTH_INIT;
              winner_out          <= 2'd0;
              countdown_out       <= 2'd3;
              layer_en_out        <= EN_COUNT;
              start_display_out   <= 1'b0;
            end
          end
          S_COUNTDOWN: begin
            // frame_cnt spans one digit, so it stays within 10 bits.
            if (frame_cnt == STEP_LAST) begin
              frame_cnt <= '0;
              if (countdown_out == 2'd1) begin
                state         <= S_PLAY;
                countdown_out <= 2'd0;
                layer_en_out  <= EN_PLAY;
              end else begin
                countdown_out <= countdown_out - 2'd1;
              end
            end else begin
              frame_cnt <= frame_cnt + 10'd1;
            end
          end
          S_PLAY: begin
            if (p_ev || o_ev) begin
              opponent_health_out <= dec_sat(opponent_health_out, p_ev);
              player_health_out   <= dec_sat(player_health_out, o_ev);
              state               <= S_HIT_FLASH;
              frame_cnt           <= '0;
              flash_out           <= 1'b1;
            end
          end
          S_HIT_FLASH: begin
            if (frame_cnt == FLASH_LAST) begin
              frame_cnt <= '0;
              flash_out <= 1'b0;
              if (player_health_out == 4'd0 || opponent_health_out == 4'd0) begin
                state             <= S_GAME_OVER;
                layer_en_out      <= EN_OVER;
                start_display_out <= 1'b1;
                // {player out, opponent out}: 1 player wins, 2 opponent wins, 3 draw.
                winner_out        <= {player_health_out == 4'd0, opponent_health_out == 4'd0};
              end else begin
                state <= S_PLAY;
              end
            end else begin
              frame_cnt <= frame_cnt + 10'd1;
            end
          end
          S_GAME_OVER: begin
            if (frame_cnt == OVER_LAST) begin
              state        <= S_IDLE;
              frame_cnt    <= '0;
              layer_en_out <= EN_IDLE;
            end else begin
              frame_cnt <= frame_cnt + 10'd1;
            end
          end
          default: begin
            state             <= S_IDLE;
            frame_cnt         <= '0;
            layer_en_out      <= EN_IDLE;
            start_display_out <= 1'b1;
            flash_out         <= 1'b0;
            countdown_out     <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_display_scene_controller.sv
// Bench for display_scene_controller: frame-level reference model checked every cycle, plus literal spot checks.
module tb_display_scene_controller;
  localparam int MAXH  = 8;
  localparam int STEP  = 60;
  localparam int FLASH = 12;
  localparam int GOV   = 300;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic       frame_start_in = 1'b0;
  logic       start_btn_in = 1'b0;
  logic       player_hit_in = 1'b0;
  logic       opponent_hit_in = 1'b0;
  logic [8:0] layer_en_out;
  logic       start_display_out;
  logic [3:0] player_health_out;
  logic [3:0] opponent_health_out;
  logic       flash_out;
  logic [1:0] countdown_out;
  logic [1:0] winner_out;
  logic [2:0] state_out;

  display_scene_controller #(
    .MAX_HEALTH(MAXH), .STEP_FRAMES(STEP), .FLASH_FRAMES(FLASH), .GAMEOVER_FRAMES(GOV)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .frame_start_in(frame_start_in),
    .start_btn_in(start_btn_in), .player_hit_in(player_hit_in), .opponent_hit_in(opponent_hit_in),
    .layer_en_out(layer_en_out), .start_display_out(start_display_out),
    .player_health_out(player_health_out), .opponent_health_out(opponent_health_out),
    .flash_out(flash_out), .countdown_out(countdown_out), .winner_out(winner_out),
    .state_out(state_out)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  // Reference model: match state, frames spent in the state, healths, winner, pending events.
  int m_st, m_fc, m_ph, m_oh, m_win;
  bit m_start, m_phit, m_ohit, m_prev;
  bit btn_next = 1'b0;
  int btn_pct = 0;

  task automatic model_reset();
    m_st = 0; m_fc = 0; m_ph = MAXH; m_oh = MAXH; m_win = 0;
    m_start = 0; m_phit = 0; m_ohit = 0; m_prev = 0;
  endtask

  task automatic model_cycle(input bit fs, input bit btn, input bit ph, input bit oh);
    bit es, ep, eo;
    es = m_start | (btn & ~m_prev);
    ep = m_phit | ph;
    eo = m_ohit | oh;
    m_prev = btn;
    if (!fs) begin
      m_start = es; m_phit = ep; m_ohit = eo;
    end else begin
      m_start = 0; m_phit = 0; m_ohit = 0;
      case (m_st)
        0: if (es) begin m_st = 1; m_fc = 0; m_ph = MAXH; m_oh = MAXH; m_win = 0; end
        1: begin
          m_fc++;
          if (m_fc == 3 * STEP) begin m_st = 2; m_fc = 0; end
        end
        2: if (ep || eo) begin
          if (ep && m_oh > 0) m_oh--;
          if (eo && m_ph > 0) m_ph--;
          m_st = 3; m_fc = 0;
        end
        3: begin
          m_fc++;
          if (m_fc == FLASH) begin
            m_fc = 0;
            if (m_ph == 0 || m_oh == 0) begin
              m_st = 4;
              m_win = (m_ph == 0 && m_oh == 0) ? 3 : ((m_oh == 0) ? 1 : 2);
            end else m_st = 2;
          end
        end
        4: begin
          m_fc++;
          if (m_fc == GOV) begin m_st = 0; m_fc = 0; end
        end
        default: m_st = 0;
      endcase
    end
  endtask

  function automatic int exp_layer(input int st);
    case (st)
      0:       return 'h007;
      1:       return 'h19B;
      2, 3:    return 'h1FB;
      default: return 'h087;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic check_model();
    check("state", int'(state_out), m_st);
    check("layer_en", int'(layer_en_out), exp_layer(m_st));
    check("start_display", int'(start_display_out), int'(m_st == 0 || m_st == 4));
    check("player_health", int'(player_health_out), m_ph);
    check("opponent_health", int'(opponent_health_out), m_oh);
    check("flash", int'(flash_out), int'(m_st == 3));
    check("countdown", int'(countdown_out), (m_st == 1) ? 3 - m_fc / STEP : 0);
    check("winner", int'(winner_out), m_win);
  endtask

  task automatic tick(input bit fs, input bit ph, input bit oh);
    @(negedge clk_in);
    check_model();
    if (btn_pct > 0 && $urandom_range(99) < btn_pct) btn_next = ~btn_next;
    frame_start_in  = fs;
    player_hit_in   = ph;
    opponent_hit_in = oh;
    start_btn_in    = btn_next;
    if (rst_n_in) model_cycle(fs, btn_next, ph, oh);
    else model_reset();
  endtask

  task automatic set_rst(input bit v);
    @(negedge clk_in);
    check_model();
    rst_n_in = v;
    frame_start_in = 0; player_hit_in = 0; opponent_hit_in = 0;
    start_btn_in = btn_next;
    if (v) model_cycle(0, btn_next, 0, 0);
    else model_reset();
  endtask

  // One frame: boundary on the first cycle; a hit index of 0 coincides with frame_start_in.
  task automatic frame_ev(input int len, input int p_at, input int o_at);
    for (int i = 0; i < len; i++) tick(i == 0, i == p_at, i == o_at);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame_ev(4, -1, -1);
  endtask

  initial begin
    model_reset();
    repeat (3) tick(0, 0, 0);
    check("reset state", int'(state_out), 0);
    check("reset layer", int'(layer_en_out), 'h007);
    check("reset start_display", int'(start_display_out), 1);
    check("reset healths", int'({player_health_out, opponent_health_out}), 'h88);
    check("reset flash/cd/win", int'({flash_out, countdown_out, winner_out}), 0);
    set_rst(1);

    frames(5);
    check("idle5 state", int'(state_out), 0);
    check("idle5 layer", int'(layer_en_out), 'h007);
    check("idle5 healths", int'({player_health_out, opponent_health_out}), 'h88);

    // Start pressed mid-frame takes effect on the next boundary.
    tick(1, 0, 0); tick(0, 0, 0);
    btn_next = 1; tick(0, 0, 0); tick(0, 0, 0);
    check("start mid-frame state", int'(state_out), 0);
    frames(1);
    btn_next = 0;
    check("countdown entry state", int'(state_out), 1);
    check("countdown entry digit", int'(countdown_out), 3);
    check("countdown layer", int'(layer_en_out), 'h19B);
    frames(59);
    check("countdown frame59", int'(countdown_out), 3);
    frames(1);
    check("countdown frame60", int'(countdown_out), 2);
    frames(60);
    check("countdown frame120", int'(countdown_out), 1);
    frames(60);
    check("play state", int'(state_out), 2);
    check("play layer", int'(layer_en_out), 'h1FB);
    check("play countdown", int'(countdown_out), 0);

    frame_ev(4, 2, -1);
    check("hit pending state", int'(state_out), 2);
    frame_ev(4, -1, -1);
    check("hit opp health", int'(opponent_health_out), 7);
    check("hit flash state", int'(state_out), 3);
    check("hit flash", int'(flash_out), 1);
    frame_ev(4, 1, 3);
    frames(10);
    check("flash frame11", int'(state_out), 3);
    frames(1);
    check("flash exit state", int'(state_out), 2);
    check("flash exit flash", int'(flash_out), 0);
    check("flash hit ignored", int'({player_health_out, opponent_health_out}), 'h87);

    frame_ev(4, 0, -1);
    check("coincident hit", int'(opponent_health_out), 6);
    frames(12);
    frame_ev(4, -1, 1);
    check("late hit pending", int'({state_out, player_health_out}), 'h28);
    frame_ev(4, -1, -1);
    check("late hit counted", int'({state_out, player_health_out}), 'h37);
    frames(12);

    for (int i = 0; i < 5; i++) begin frame_ev(4, 0, -1); frames(12); end
    for (int i = 0; i < 6; i++) begin frame_ev(4, -1, 0); frames(12); end
    check("healths 1/1", int'({state_out, player_health_out, opponent_health_out}), 'h211);
    frame_ev(4, 2, 3);
    frame_ev(4, -1, -1);
    check("double touch", int'({state_out, player_health_out, opponent_health_out}), 'h300);
    frames(12);
    check("game over state", int'(state_out), 4);
    check("game over winner", int'(winner_out), 3);
    check("game over layer", int'(layer_en_out), 'h087);
    frames(299);
    check("game over hold", int'(state_out), 4);
    frames(1);
    check("back to idle", int'({state_out, player_health_out, opponent_health_out}), 'h000);
    check("idle winner held", int'(winner_out), 3);

    // Reset in the middle of a hit flash.
    btn_next = 1; frames(1); btn_next = 0;
    check("restart state", int'({state_out, winner_out}), 'h4);
    frames(180);
    frame_ev(4, 0, 0);
    check("second flash", int'({state_out, player_health_out, opponent_health_out}), 'h377);
    frames(3);
    set_rst(0);
    #1;
    check("async rst state", int'(state_out), 0);
    check("async rst layer", int'(layer_en_out), 'h007);
    check("async rst healths", int'({player_health_out, opponent_health_out}), 'h88);
    check("async rst flash", int'(flash_out), 0);
    tick(0, 0, 0); tick(0, 0, 0);
    set_rst(1);
    tick(1, 0, 0); btn_next = 1; tick(0, 0, 0); tick(0, 0, 0); btn_next = 0;
    frames(1);
    check("post-reset start", int'({state_out, countdown_out}), 'h7);

    // Randomized play against the model.
    btn_pct = 3;
    for (int f = 0; f < 2500; f++) begin
      int len, pa, oa;
      len = $urandom_range(7, 1);
      pa = ($urandom_range(3) == 0) ? $urandom_range(len - 1) : -1;
      oa = ($urandom_range(3) == 0) ? $urandom_range(len - 1) : -1;
      if (f == 1200) begin
        set_rst(0); tick(0, 0, 0); set_rst(1);
      end
      frame_ev(len, pa, oa);
    end
    btn_pct = 0;
    tick(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
